alu_ctrl_idex: RTL and testbench

ID/EX-stage producer for the EX-stage ALU. It decodes OpCode/Funct into the 5-bit ALUCtl code and the Sign flag, and selects and extends the ALU operands (shamt, immediate, register data). It registers the result into the ID/EX pipeline register, with stall (hold) and flush (bubble) control driven by the hazard unit.

---
 rtl/alu_ctrl_idex.sv | 151 +++++++++++++++
 tb/tb_alu_ctrl_idex.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_ctrl_idex.sv
// alu_ctrl_idex: ID/EX producer for the EX-stage ALU.
// Decodes OpCode/Funct into the ALU control code and signed-compare flag,
// selects and extends the ALU operands, and registers everything into the
// ID/EX pipeline register under hazard-unit stall/flush control.
module alu_ctrl_idex #(
    parameter int SHAMT_LUI = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        id_valid,
    input  logic [5:0]  OpCode,
    input  logic [5:0]  Funct,
    input  logic [4:0]  Shamt,
    input  logic [15:0] Imm16,
    input  logic [31:0] rs_data,
    input  logic [31:0] rt_data,
    input  logic        stall,
    input  logic        flush,
    output logic        ex_valid,
    output logic [4:0]  ex_ALUCtl,
    output logic        ex_Sign,
    output logic [31:0] ex_in1,
    output logic [31:0] ex_in2,
    output logic        ex_illegal
);

    localparam logic [4:0] ALU_AND = 5'b00000;
    localparam logic [4:0] ALU_OR  = 5'b00001;
    localparam logic [4:0] ALU_ADD = 5'b00010;
    localparam logic [4:0] ALU_SUB = 5'b00110;
    localparam logic [4:0] ALU_SLT = 5'b00111;
    localparam logic [4:0] ALU_NOR = 5'b01100;
    localparam logic [4:0] ALU_XOR = 5'b01101;
    localparam logic [4:0] ALU_SLL = 5'b10000;
    localparam logic [4:0] ALU_SRL = 5'b11000;
    localparam logic [4:0] ALU_SRA = 5'b11001;

    localparam logic [31:0] LUI_SHIFT = 32'(SHAMT_LUI);

    logic        valid_q,   valid_d;
    logic [4:0]  aluCtl_q,  aluCtl_d;
    logic        sign_q,    sign_d;
    logic [31:0] in1_q,     in1_d;
    logic [31:0] in2_q,     in2_d;
    logic        illegal_q, illegal_d;
    logic        decIllegal;

    logic [31:0] immSe;
    logic [31:0] immZe;

    assign immSe = {{16{Imm16[15]}}, Imm16};
    assign immZe = {16'h0000, Imm16};

    // Instruction decode: control code, sign flag and operand selection.
    // Unknown encodings become a zero-operand AND flagged as illegal so the
    // exception can be raised further down the pipe.
    always_comb begin
        aluCtl_d   = ALU_AND;
        sign_d     = 1'b1;
        in1_d      = rs_data;
        in2_d      = rt_data;
        decIllegal = 1'b0;

        unique case (OpCode)
            6'h00: begin
                unique case (Funct)
                    6'h20: aluCtl_d = ALU_ADD;
                    6'h21: begin aluCtl_d = ALU_ADD; sign_d = 1'b0; end
                    6'h22: aluCtl_d = ALU_SUB;
                    6'h23: begin aluCtl_d = ALU_SUB; sign_d = 1'b0; end
                    6'h24: aluCtl_d = ALU_AND;
                    6'h25: aluCtl_d = ALU_OR;
                    6'h26: aluCtl_d = ALU_XOR;
                    6'h27: aluCtl_d = ALU_NOR;
                    6'h2a: aluCtl_d = ALU_SLT;
                    6'h2b: begin aluCtl_d = ALU_SLT; sign_d = 1'b0; end
                    6'h00: begin aluCtl_d = ALU_SLL; in1_d = {27'b0, Shamt}; end
                    6'h02: begin aluCtl_d = ALU_SRL; in1_d = {27'b0, Shamt}; end
                    6'h03: begin aluCtl_d = ALU_SRA; in1_d = {27'b0, Shamt}; end
                    6'h04: aluCtl_d = ALU_SLL;
                    6'h06: aluCtl_d = ALU_SRL;
                    6'h07: aluCtl_d = ALU_SRA;
                    6'h08, 6'h09: aluCtl_d = ALU_ADD;
                    default: begin
                        aluCtl_d   = ALU_AND;
                        sign_d     = 1'b0;
                        in1_d      = 32'h0;
                        in2_d      = 32'h0;
                        decIllegal = 1'b1;
                    end
                endcase
            end
            6'h08: begin aluCtl_d = ALU_ADD; in2_d = immSe; end
            6'h09: begin aluCtl_d = ALU_ADD; in2_d = immSe; sign_d = 1'b0; end
            6'h0a: begin aluCtl_d = ALU_SLT; in2_d = immSe; end
            6'h0b: begin aluCtl_d = ALU_SLT; in2_d = immSe; sign_d = 1'b0; end
            6'h0c: begin aluCtl_d = ALU_AND; in2_d = immZe; end
            6'h0d: begin aluCtl_d = ALU_OR;  in2_d = immZe; end
            6'h0e: begin aluCtl_d = ALU_XOR; in2_d = immZe; end
            6'h23, 6'h2b: begin aluCtl_d = ALU_ADD; in2_d = immSe; end
            6'h0f: begin aluCtl_d = ALU_SLL; in1_d = LUI_SHIFT; in2_d = immZe; end
            6'h04, 6'h05: aluCtl_d = ALU_SUB;
            6'h02, 6'h03: aluCtl_d = ALU_ADD;
            default: begin
                aluCtl_d   = ALU_AND;
                sign_d     = 1'b0;
                in1_d      = 32'h0;
                in2_d      = 32'h0;
                decIllegal = 1'b1;
            end
        endcase

        valid_d   = id_valid;
        illegal_d = decIllegal & id_valid;
    end

    // ID/EX pipeline register: flush inserts an all-zero bubble and beats
    // stall; stall holds; otherwise load the fresh decode.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q   <= 1'b0;
            aluCtl_q  <= 5'b0;
            sign_q    <= 1'b0;
            in1_q     <= 32'h0;
            in2_q     <= 32'h0;
            illegal_q <= 1'b0;
        end else if (flush) begin
            valid_q   <= 1'b0;
            aluCtl_q  <= 5'b0;
            sign_q    <= 1'b0;
            in1_q     <= 32'h0;
            in2_q     <= 32'h0;
            illegal_q <= 1'b0;
        end else if (!stall) begin
            valid_q   <= valid_d;
            aluCtl_q  <= aluCtl_d;
            sign_q    <= sign_d;
            in1_q     <= in1_d;
            in2_q     <= in2_d;
            illegal_q <= illegal_d;
        end
    end

    assign ex_valid   = valid_q;
    assign ex_ALUCtl  = aluCtl_q;
    assign ex_Sign    = sign_q;
    assign ex_in1     = in1_q;
    assign ex_in2     = in2_q;
    assign ex_illegal = illegal_q;

endmodule

// File: tb/tb_alu_ctrl_idex.sv
// tb_alu_ctrl_idex: directed testbench for the ID/EX ALU control producer.
module tb_alu_ctrl_idex;

    logic        clk;
    logic        reset;
    logic        id_valid;
    logic [5:0]  OpCode;
    logic [5:0]  Funct;
    logic [4:0]  Shamt;
    logic [15:0] Imm16;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic        stall;
    logic        flush;
    logic        ex_valid;
    logic [4:0]  ex_ALUCtl;
    logic        ex_Sign;
    logic [31:0] ex_in1;
    logic [31:0] ex_in2;
    logic        ex_illegal;

    int checks;
    int failures;

    logic [71:0] obs;
    logic [71:0] expv;

    alu_ctrl_idex #(.SHAMT_LUI(16)) dut (
        .clk        (clk),
        .reset      (reset),
        .id_valid   (id_valid),
        .OpCode     (OpCode),
        .Funct      (Funct),
        .Shamt      (Shamt),
        .Imm16      (Imm16),
        .rs_data    (rs_data),
        .rt_data    (rt_data),
        .stall      (stall),
        .flush      (flush),
        .ex_valid   (ex_valid),
        .ex_ALUCtl  (ex_ALUCtl),
        .ex_Sign    (ex_Sign),
        .ex_in1     (ex_in1),
        .ex_in2     (ex_in2),
        .ex_illegal (ex_illegal)
    );

    assign obs = {ex_valid, ex_ALUCtl, ex_Sign, ex_in1, ex_in2, ex_illegal};

    // Free-running clock, period 10.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Watchdog so the run can never hang.
    initial begin
        #100000;
        $display("[TB] FAIL watchdog got=timeout exp=finish");
        $fatal(1, "[TB] timeout");
    end

    function automatic logic [71:0] pack(input logic v, input logic [4:0] c, input logic s,
                                         input logic [31:0] a, input logic [31:0] b,
                                         input logic ill);
        return {v, c, s, a, b, ill};
    endfunction

    // Drive one set of ID inputs on the falling edge, then settle #1 past
    // the next rising edge where outputs are sampled.
    task automatic applyStimulus(input logic [5:0] op, input logic [5:0] fn,
                                 input logic [4:0] sh, input logic [15:0] imm,
                                 input logic [31:0] rs, input logic [31:0] rt,
                                 input logic v, input logic st, input logic fl);
        @(negedge clk);
        OpCode   = op;
        Funct    = fn;
        Shamt    = sh;
        Imm16    = imm;
        rs_data  = rs;
        rt_data  = rt;
        id_valid = v;
        stall    = st;
        flush    = fl;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        applyStimulus(6'h00, 6'h20, 5'd0, 16'h0, 32'h1234_5678, 32'h9, 1'b1, 1'b0, 1'b0);
        expv = pack(1'b1, 5'b00010, 1'b1, 32'h1234_5678, 32'h9, 1'b0);
        checks++;
        if (obs !== expv) begin
            $display("[TB] FAIL pre_reset_load got=%h exp=%h", obs, expv);
            failures++;
        end
        #2 reset = 1'b1;
        #1;
        expv = '0;
        checks++;
        if (obs !== expv) begin
            $display("[TB] FAIL async_reset got=%h exp=%h", obs, expv);
            failures++;
        end
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_rtype();
        applyStimulus(6'h00, 6'h20, 5'd0, 16'h0, 32'h7FFF_FFFF, 32'h1, 1'b1, 1'b0, 1'b0);
        expv = pack(1'b1, 5'b00010, 1'b1, 32'h7FFF_FFFF, 32'h1, 1'b0);
        checks++;
        if (obs !== expv) begin
            $display("[TB] FAIL add got=%h exp=%h", obs, expv);
            failures++;
        end
        applyStimulus(6'h00, 6'h21, 5'd0, 16'h0, 32'h7FFF_FFFF, 32'h1, 1'b1, 1'b0, 1'b0);
        expv = pack(1'b1, 5'b00010, 1'b0, 32'h7FFF_FFFF, 32'h1, 1'b0);
        checks++;
        if (obs !== expv) begin
            $display("[TB] FAIL addu got=%h exp=%h", obs, expv);
            failures++;
        end
        applyStimulus(6'h00, 6'h03, 5'd4, 16'h0, 32'h1234_5678, 32'h8000_0000, 1'b1, 1'b0, 1'b0);
        expv = pack(1'b1, 5'b11001, 1'b1, 32'h0000_0004, 32'h8000_0000, 1'b0);
        checks++;
        if (obs !== expv) begin
            $display("[TB] FAIL sra got=%h exp=%h", obs, expv);
            failures++;
        end
        applyStimulus(6'h00, 6'h06, 5'd9, 16'h0, 32'h0000_0013, 32'hF0F0_0000, 1'b1, 1'b0, 1'b0);
        expv = pack(1'b1, 5'b11000, 1'b1, 32'h0000_0013, 32'hF0F0_0000, 1'b0);
        checks++;
        if (obs !== expv) begin
            $display("[TB] FAIL srlv got=%h exp=%h", obs, expv);
            failures++;
        end
        applyStimulus(6'h00, 6'h2b, 5'd0, 16'h0, 32'hFFFF_FFFE, 32'h3, 1'b1, 1'b0, 1'b0);
        expv = pack(1'b1, 5'b00111, 1'b0, 32'hFFFF_FFFE, 32'h3, 1'b0);
        checks++;
        if (obs !== expv) begin
            $display("[TB] FAIL sltu got=%h exp=%h", obs, expv);
            failures++;
        end
        applyStimulus(6'h00, 6'h27, 5'd0, 16'h0, 32'hA5A5_0000, 32'h0000_5A5A, 1'b1, 1'b0, 1'b0);
        expv = pack(1'b1, 5'b01100, 1'b1, 32'hA5A5_0000, 32'h0000_5A5A, 1'b0);
        checks++;
        if (obs !== expv) begin
            $display("[TB] FAIL nor got=%h exp=%h", obs, expv);
            failures++;
        end
    endtask

    task automatic test_itype();
        applyStimulus(6'h0f, 6'h15, 5'd7, 16'hABCD, 32'hDEAD_BEEF, 32'h77, 1'b1, 1'b0, 1'b0);
        expv = pack(1'b1, 5'b10000, 1'b1, 32'h0000_0010, 32'h0000_ABCD, 1'b0);
        checks++;
        if (obs !== expv) begin
            $display("[TB] FAIL lui got=%h exp=%h", obs, expv);
            failures++;
        end
        applyStimulus(6'h0b, 6'h00, 5'd0, 16'hFFFF, 32'h0000_0005, 32'h77, 1'b1, 1'b0, 1'b0);
        expv = pack(1'b1, 5'b00111, 1'b0, 32'h0000_0005, 32'hFFFF_FFFF, 1'b0);
        checks++;
        if (obs !== expv) begin
            $display("[TB] FAIL sltiu got=%h exp=%h", obs, expv);
            failures++;
        end
        applyStimulus(6'h0c, 6'h00, 5'd0, 16'hFFFF, 32'hAAAA_5555, 32'h77, 1'b1, 1'b0, 1'b0);
        expv = pack(1'b1, 5'b00000, 1'b1, 32'hAAAA_5555, 32'h0000_FFFF, 1'b0);
        checks++;
        if (obs !== expv) begin
            $display("[TB] FAIL andi got=%h exp=%h", obs, expv);
            failures++;
        end
        applyStimulus(6'h23, 6'h00, 5'd0, 16'hFFFC, 32'h0000_1000, 32'h77, 1'b1, 1'b0, 1'b0);
        expv = pack(1'b1, 5'b00010, 1'b1, 32'h0000_1000, 32'hFFFF_FFFC, 1'b0);
        checks++;
        if (obs !== expv) begin
            $display("[TB] FAIL lw got=%h exp=%h", obs, expv);
            failures++;
        end
        applyStimulus(6'h05, 6'h00, 5'd0, 16'h0004, 32'h0000_0042, 32'h0000_0043, 1'b1, 1'b0, 1'b0);
        expv = pack(1'b1, 5'b00110, 1'b1, 32'h0000_0042, 32'h0000_0043, 1'b0);
        checks++;
        if (obs !== expv) begin
            $display("[TB] FAIL bne got=%h exp=%h", obs, expv);
            failures++;
        end
    endtask

    task automatic test_stall_flush();
        applyStimulus(6'h08, 6'h00, 5'd0, 16'h8000, 32'h0000_0100, 32'h5, 1'b1, 1'b0, 1'b0);
        expv = pack(1'b1, 5'b00010, 1'b1, 32'h0000_0100, 32'hFFFF_8000, 1'b0);
        checks++;
        if (obs !== expv) begin
            $display("[TB] FAIL addi got=%h exp=%h", obs, expv);
            failures++;
        end
        for (int i = 0; i < 3; i++) begin
            applyStimulus(6'h00, 6'h22, 5'(i + 1), 16'(i * 3 + 1), 32'(i + 100),
                          32'(i + 200), i[0], 1'b1, 1'b0);
            checks++;
            if (obs !== expv) begin
                $display("[TB] FAIL stall_hold%0d got=%h exp=%h", i, obs, expv);
                failures++;
            end
        end
        applyStimulus(6'h00, 6'h22, 5'd0, 16'h0, 32'h9, 32'h8, 1'b1, 1'b1, 1'b1);
        expv = '0;
        checks++;
        if (obs !== expv) begin
            $display("[TB] FAIL stall_flush got=%h exp=%h", obs, expv);
            failures++;
        end
        applyStimulus(6'h0d, 6'h00, 5'd0, 16'h8001, 32'h0000_00F0, 32'h8, 1'b1, 1'b0, 1'b0);
        expv = pack(1'b1, 5'b00001, 1'b1, 32'h0000_00F0, 32'h0000_8001, 1'b0);
        checks++;
        if (obs !== expv) begin
            $display("[TB] FAIL ori_after_flush got=%h exp=%h", obs, expv);
            failures++;
        end
        applyStimulus(6'h0e, 6'h00, 5'd0, 16'h1234, 32'h0000_0001, 32'h8, 1'b1, 1'b0, 1'b1);
        expv = '0;
        checks++;
        if (obs !== expv) begin
            $display("[TB] FAIL flush_only got=%h exp=%h", obs, expv);
            failures++;
        end
        applyStimulus(6'h0e, 6'h00, 5'd0, 16'h1234, 32'h0000_0001, 32'h8, 1'b1, 1'b0, 1'b0);
        applyStimulus(6'h00, 6'h20, 5'd0, 16'h0, 32'h5, 32'h6, 1'b1, 1'b1, 1'b0);
        #2 reset = 1'b1;
        #1;
        expv = '0;
        checks++;
        if (obs !== expv) begin
            $display("[TB] FAIL reset_mid_stall got=%h exp=%h", obs, expv);
            failures++;
        end
        @(negedge clk);
        reset = 1'b0;
        applyStimulus(6'h00, 6'h26, 5'd0, 16'h0, 32'h0000_FF00, 32'h0000_0FF0, 1'b1, 1'b0, 1'b0);
        expv = pack(1'b1, 5'b01101, 1'b1, 32'h0000_FF00, 32'h0000_0FF0, 1'b0);
        checks++;
        if (obs !== expv) begin
            $display("[TB] FAIL xor_after_reset got=%h exp=%h", obs, expv);
            failures++;
        end
    endtask

    task automatic test_illegal();
        applyStimulus(6'h3F, 6'h20, 5'd3, 16'h1111, 32'hCAFE_F00D, 32'h1234, 1'b1, 1'b0, 1'b0);
        expv = pack(1'b1, 5'b00000, 1'b0, 32'h0, 32'h0, 1'b1);
        checks++;
        if (obs !== expv) begin
            $display("[TB] FAIL illegal_op got=%h exp=%h", obs, expv);
            failures++;
        end
        applyStimulus(6'h3F, 6'h20, 5'd3, 16'h1111, 32'hCAFE_F00D, 32'h1234, 1'b0, 1'b0, 1'b0);
        expv = '0;
        checks++;
        if (obs !== expv) begin
            $display("[TB] FAIL illegal_invalid got=%h exp=%h", obs, expv);
            failures++;
        end
        applyStimulus(6'h00, 6'h01, 5'd0, 16'h0, 32'h1, 32'h2, 1'b1, 1'b0, 1'b0);
        expv = pack(1'b1, 5'b00000, 1'b0, 32'h0, 32'h0, 1'b1);
        checks++;
        if (obs !== expv) begin
            $display("[TB] FAIL illegal_funct got=%h exp=%h", obs, expv);
            failures++;
        end
        applyStimulus(6'h00, 6'h09, 5'd0, 16'h0, 32'h0040_0000, 32'h0, 1'b0, 1'b0, 1'b0);
        expv = pack(1'b0, 5'b00010, 1'b1, 32'h0040_0000, 32'h0, 1'b0);
        checks++;
        if (obs !== expv) begin
            $display("[TB] FAIL jalr_invalid got=%h exp=%h", obs, expv);
            failures++;
        end
    endtask

    // Test sequence.
    initial begin
        checks   = 0;
        failures = 0;
        reset    = 1'b1;
        id_valid = 1'b0;
        OpCode   = 6'h0;
        Funct    = 6'h0;
        Shamt    = 5'h0;
        Imm16    = 16'h0;
        rs_data  = 32'h0;
        rt_data  = 32'h0;
        stall    = 1'b0;
        flush    = 1'b0;
        #12;
        expv = '0;
        checks++;
        if (obs !== expv) begin
            $display("[TB] FAIL power_on_reset got=%h exp=%h", obs, expv);
            failures++;
        end
        @(negedge clk);
        reset = 1'b0;

        test_reset();
        test_rtype();
        test_itype();
        test_stall_flush();
        test_illegal();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
